// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one MEM-stage load/store, performs it on a word RAM
// and returns an extended load result. Optional misalignment check: DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rd_q;
  logic          we_q;
  logic          err_q;
  logic          uns_q;
  logic [1:0]    addr_q;
  logic [1:0]    size_q;
  logic [AW-1:0] idx;
  logic          accept;
  logic          misaligned;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;
  logic          unused_addr;

  assign idx         = req_addr[AW+1:2];
  assign unused_addr = ^req_addr[31:AW+2];
  assign accept      = req_valid && (state == IDLE);
  assign req_ready   = (state == IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd1:       misaligned = req_addr[0];
      2'd2, 2'd3: misaligned = (req_addr[1:0] != 2'd0);
      default:    misaligned = 1'b0;
    endcase
    if (req_we && (req_wstrb == 4'd0))
      misaligned = 1'b1;
  end
`else
  assign misaligned = 1'b0;
`endif

  // RAM is not reset; the read is registered on the accepting edge alongside any write.
  always_ff @(posedge aclk) begin
    if (accept) begin
      if (req_we && !misaligned) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (req_wstrb[i])
            mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
      rd_q <= mem[idx];
    end
  end

  // A half at lane 3 shifts zeros into bits [15:8]; no cross-word access.
  always_comb begin
    shifted  = rd_q >> {addr_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      2'd0:    load_ext = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      2'd1:    load_ext = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q   <= req_we;
            err_q  <= misaligned;
            uns_q  <= req_unsigned;
            addr_q <= req_addr[1:0];
            size_q <= req_size;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= (we_q || err_q) ? '0 : load_ext;
          rsp_err   <= err_q;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stores/loads with extension, partial store,
// wrap, backpressure, reset in RESP, and the misalignment check when DMEM_ALIGN_CHECK_EN is set.
module tb_dmem_responder;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_wstrb = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vectors = 0;
  int miscompares = 0;

  dmem_responder #(.DEPTH_WORDS(1024)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request; returns at E1+1 with rsp_valid expected high.
  task automatic issue(input logic we, input logic [3:0] wstrb, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    int cycles;
    check("req_ready_before", req_ready, 1);
    req_we = we; req_wstrb = wstrb; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns; req_valid = 1'b1;
    @(posedge aclk); #1;
    req_valid = 1'b0;
    check("valid_after_e0", rsp_valid, 0);
    cycles = 0;
    while (!rsp_valid && cycles < 8) begin
      @(posedge aclk); #1;
      cycles++;
    end
    check("latency", cycles, 1);
  endtask

  task automatic txn(input string tag, input logic we, input logic [3:0] wstrb,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size,
                     input logic uns, input logic [31:0] exp_data, input logic exp_err);
    issue(we, wstrb, addr, wdata, size, uns);
    check(tag, rsp_rdata, exp_data);
    check({tag, "_err"}, rsp_err, exp_err);
    check({tag, "_busy"}, req_ready, 0);
    @(posedge aclk); #1;
    check({tag, "_valid_drop"}, rsp_valid, 0);
    check({tag, "_ready_back"}, req_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge aclk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    areset = 1'b0;
    #2;

    txn("st_w_10",  1'b1, 4'b1111, 32'h10, 32'h8081F2F3, 2'd2, 1'b0, 32'h0, 1'b0);
    txn("ld_b_11",  1'b0, 4'b0000, 32'h11, 32'h0, 2'd0, 1'b0, 32'hFFFFFFF2, 1'b0);
    txn("ld_bu_13", 1'b0, 4'b0000, 32'h13, 32'h0, 2'd0, 1'b1, 32'h00000080, 1'b0);
    txn("ld_h_12",  1'b0, 4'b0000, 32'h12, 32'h0, 2'd1, 1'b0, 32'hFFFF8081, 1'b0);
    txn("ld_hu_10", 1'b0, 4'b0000, 32'h10, 32'h0, 2'd1, 1'b1, 32'h0000F2F3, 1'b0);
    txn("ld_b_10",  1'b0, 4'b0000, 32'h10, 32'h0, 2'd0, 1'b0, 32'hFFFFFFF3, 1'b0);

    txn("st_b_12",  1'b1, 4'b0100, 32'h12, 32'h00AA0000, 2'd0, 1'b0, 32'h0, 1'b0);
    txn("ld_w_10",  1'b0, 4'b0000, 32'h10, 32'h0, 2'd2, 1'b0, 32'h80AAF2F3, 1'b0);
    txn("ld_rsv_10", 1'b0, 4'b0000, 32'h10, 32'h0, 2'd3, 1'b0, 32'h80AAF2F3, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    txn("ld_w_11_mis", 1'b0, 4'b0000, 32'h11, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1);
    txn("ld_h_13_mis", 1'b0, 4'b0000, 32'h13, 32'h0, 2'd1, 1'b0, 32'h0, 1'b1);
    txn("st_h_13_mis", 1'b1, 4'b1000, 32'h13, 32'h11223344, 2'd1, 1'b0, 32'h0, 1'b1);
    txn("st_w_nostrb", 1'b1, 4'b0000, 32'h10, 32'h11223344, 2'd2, 1'b0, 32'h0, 1'b1);
    txn("ld_w_10_kept", 1'b0, 4'b0000, 32'h10, 32'h0, 2'd2, 1'b0, 32'h80AAF2F3, 1'b0);
`else
    txn("ld_h_13_trunc",  1'b0, 4'b0000, 32'h13, 32'h0, 2'd1, 1'b0, 32'h00000080, 1'b0);
    txn("ld_w_11_shift",  1'b0, 4'b0000, 32'h11, 32'h0, 2'd2, 1'b0, 32'h0080AAF2, 1'b0);
`endif

    txn("st_w_1000", 1'b1, 4'b1111, 32'h1000, 32'h12345678, 2'd2, 1'b0, 32'h0, 1'b0);
    txn("ld_w_0",    1'b0, 4'b0000, 32'h0, 32'h0, 2'd2, 1'b0, 32'h12345678, 1'b0);

    rsp_ready = 1'b0;
    issue(1'b0, 4'b0000, 32'h10, 32'h0, 2'd2, 1'b0);
    repeat (5) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_rdata", rsp_rdata, 32'h80AAF2F3);
      check("bp_req_ready", req_ready, 0);
      @(posedge aclk); #1;
    end
    rsp_ready = 1'b1;
    check("bp_valid_last", rsp_valid, 1);
    @(posedge aclk); #1;
    check("bp_valid_drop", rsp_valid, 0);
    check("bp_req_ready_back", req_ready, 1);

    txn("st_w_20", 1'b1, 4'b1111, 32'h20, 32'hCAFEBABE, 2'd2, 1'b0, 32'h0, 1'b0);
    rsp_ready = 1'b0;
    issue(1'b0, 4'b0000, 32'h20, 32'h0, 2'd2, 1'b0);
    check("mr_rdata_pre", rsp_rdata, 32'hCAFEBABE);
    areset = 1'b1;
    #1;
    check("mr_valid", rsp_valid, 0);
    check("mr_rdata", rsp_rdata, 0);
    check("mr_req_ready", req_ready, 1);
    @(posedge aclk); #1;
    areset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("mr_req_ready_rel", req_ready, 1);
    txn("ld_w_20_after_rst", 1'b0, 4'b0000, 32'h20, 32'h0, 2'd2, 1'b0, 32'hCAFEBABE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
